// File: rtl/rll27_encoder.sv
// RLL(2,7) encoder: parses parallel data words MSB-first into variable-length
//   source words and emits the rate-1/2 code stream serially, plus an NRZI line level.
// Latency: word accepted at edge t, first code word loaded at edge t+1, first code bit
//   valid in the cycle after t+1.
// Backpressure: din_ready only while the bit buffer has room for a whole word and no
//   flush is pending. The code stream stalls, and underrun flags it, when the buffer starves.
//
// Ports:
//   clk, rst    single clock, synchronous active-high reset
//   din         data word, MSB first in time; din_valid/din_ready handshake
//   flush       one-cycle pulse: end of stream, pad and drain the residual bits
//   code_out    serial code bit, qualified by code_valid
//   nrzi_out    NRZI line level (or code_out itself when NRZI_EN=0)
//   underrun    shifter empty while busy and not flushing
//   busy        buffer, shifter or pending flush non-empty
//
// DATA_W must be at least 2 so that the parser can always look at 4 head bits.

module rll27_encoder #(
  parameter int DATA_W  = 8,
  parameter bit NRZI_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              flush,
  output logic              code_out,
  output logic              code_valid,
  output logic              nrzi_out,
  output logic              underrun,
  output logic              busy
);

  localparam int BQ_W  = 2 * DATA_W;
  localparam int CNT_W = $clog2(BQ_W + 1);

  // Bit buffer: the oldest bit sits at bq[BQ_W-1]. Bits below the valid count
  // are always zero, which is what makes end-of-stream padding free.
  logic [BQ_W-1:0]  bq;
  logic [CNT_W-1:0] bq_cnt;
  // Code shifter: the code word is left-aligned, and the MSB is the bit on the wire.
  logic [7:0]       sh;
  logic [3:0]       sh_cnt;
  logic             flush_pend;
  logic             nrzi_q;

  logic [3:0]       hd;
  logic [CNT_W-1:0] src_len;
  logic [3:0]       code_len;
  logic [7:0]       code;
  logic             full_word;
  logic             pad_word;
  logic             load;
  logic             accept;
  logic [CNT_W-1:0] consume;
  logic [CNT_W-1:0] cnt_left;
  logic [BQ_W-1:0]  app;

  assign hd = bq[BQ_W-1 -: 4];

  // Table lookup on the head bits. The code table is prefix-free, so the head
  // alone selects the entry; whether enough bits are present is checked separately.
  always_comb begin
    src_len  = CNT_W'(3);
    code_len = 4'd6;
    code     = 8'h00;
    if (hd[3]) begin
      src_len  = CNT_W'(2);
      code_len = 4'd4;
      code     = hd[2] ? 8'b1000_0000 : 8'b0100_0000;
    end else if (hd[2:1] == 2'b01) begin
      src_len  = CNT_W'(4);
      code_len = 4'd8;
      code     = hd[0] ? 8'b0000_1000 : 8'b0010_0100;
    end else begin
      case (hd[2:1])
        2'b00:   code = 8'b0001_0000;
        2'b10:   code = 8'b1001_0000;
        default: code = 8'b0010_0000;
      endcase
    end
  end

  // A short residual word at end of stream is read with zero padding. The zeros
  // are already in the buffer, so only the consumed count differs.
  assign full_word = (bq_cnt >= src_len);
  assign pad_word  = flush_pend & (bq_cnt != '0) & ~full_word;

  // Reload while the last bit is still being issued, so code words go out back to back.
  assign load    = (full_word | pad_word) & (sh_cnt <= 4'd1);
  assign consume = load ? (full_word ? src_len : bq_cnt) : '0;

  assign din_ready = (bq_cnt <= CNT_W'(DATA_W)) & ~flush_pend & ~rst;
  assign accept    = din_valid & din_ready;

  // The new word lands directly behind the bits that remain after this cycle's consume.
  assign cnt_left = bq_cnt - consume;
  assign app      = accept ? ({din, {DATA_W{1'b0}}} >> cnt_left) : '0;

  assign code_valid = (sh_cnt != 4'd0);
  assign code_out   = code_valid & sh[7];
  assign busy       = (bq_cnt != '0) | code_valid | flush_pend;
  assign underrun   = ~code_valid & busy & ~flush_pend;
  assign nrzi_out   = NRZI_EN ? nrzi_q : code_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      bq         <= '0;
      bq_cnt     <= '0;
      sh         <= '0;
      sh_cnt     <= '0;
      flush_pend <= 1'b0;
      nrzi_q     <= 1'b0;
    end else begin
      bq     <= (bq << consume) | app;
      bq_cnt <= cnt_left + (accept ? CNT_W'(DATA_W) : '0);

      if (load) begin
        sh     <= code;
        sh_cnt <= code_len;
      end else if (sh_cnt != 4'd0) begin
        sh     <= sh << 1;
        sh_cnt <= sh_cnt - 4'd1;
      end

      if (flush) begin
        flush_pend <= 1'b1;
      end else if (flush_pend && (bq_cnt == '0) && (sh_cnt == 4'd0)) begin
        flush_pend <= 1'b0;
      end

      if (NRZI_EN && code_out) begin
        nrzi_q <= ~nrzi_q;
      end
    end
  end

endmodule

// File: tb/tb_rll27_encoder.sv
// Directed bench for rll27_encoder (DATA_W=8, NRZI_EN=1).
// Each scenario task drives its stimulus and compares against hand-computed values.
// The random stream is compared against a table-driven reference encoder.

module tb_rll27_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       flush = 1'b0;
  logic       din_ready, code_out, code_valid, nrzi_out, underrun, busy;

  rll27_encoder #(.DATA_W(8), .NRZI_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .flush      (flush),
    .code_out   (code_out),
    .code_valid (code_valid),
    .nrzi_out   (nrzi_out),
    .underrun   (underrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   first_v, last_v, acc_cyc;
  logic got[$];
  logic nz[$];
  logic src[$];
  logic mdl[$];

  // Reference code table: source pattern (right-aligned) -> code word (right-aligned)
  logic [3:0] pv [7] = '{4'b0010, 4'b0011, 4'b0000, 4'b0010, 4'b0011, 4'b0010, 4'b0011};
  int         pl [7] = '{2, 2, 3, 3, 3, 4, 4};
  logic [7:0] cv [7] = '{8'b0000_0100, 8'b0000_1000, 8'b0000_0100, 8'b0010_0100,
                         8'b0000_1000, 8'b0010_0100, 8'b0000_1000};
  int         cl [7] = '{4, 4, 6, 6, 6, 8, 8};

  // One clock: sample just after the edge, logging every code bit and its NRZI level.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (code_valid) begin
      if (got.size() == 0) first_v = cyc;
      last_v = cyc;
      got.push_back(code_out);
      nz.push_back(nrzi_out);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    got.delete(); nz.delete(); src.delete(); mdl.delete();
    first_v = -1; last_v = -1;
  endtask

  task automatic send_word(input logic [7:0] w);
    int n;
    n = 0;
    din = w; din_valid = 1'b1;
    while (!din_ready && n < 100) begin tick(); n++; end
    total++;
    if (!din_ready) begin
      bad++;
      $display("FAIL send_word_ready: din_ready=%b after %0d cycles, required 1", din_ready, n);
    end
    acc_cyc = cyc + 1;
    tick();
    din_valid = 1'b0; din = 8'h00;
    for (int i = 7; i >= 0; i--) src.push_back(w[i]);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 500) begin tick(); n++; end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL drain_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  function automatic logic [63:0] pack_got();
    logic [63:0] v;
    v = '0;
    foreach (got[i]) v = {v[62:0], got[i]};
    return v;
  endfunction

  function automatic logic [63:0] pack_nz();
    logic [63:0] v;
    v = '0;
    foreach (nz[i]) v = {v[62:0], nz[i]};
    return v;
  endfunction

  task automatic build_model();
    int p, hit;
    logic ok, b;
    p = 0;
    while (p < src.size()) begin
      hit = -1;
      for (int k = 0; k < 7; k++) begin
        ok = 1'b1;
        for (int j = 0; j < pl[k]; j++) begin
          b = (p + j < src.size()) ? src[p + j] : 1'b0;
          if (b != pv[k][pl[k] - 1 - j]) ok = 1'b0;
        end
        if (ok && hit < 0) hit = k;
      end
      if (hit < 0) break;
      for (int j = 0; j < cl[hit]; j++) mdl.push_back(cv[hit][cl[hit] - 1 - j]);
      p += pl[hit];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++;
    if (din_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst: din_ready=%b required 0", din_ready); end
    rst = 1'b0;
    #1;
    total++;
    if ({code_valid, code_out, nrzi_out, underrun, busy, din_ready} !== 6'b000001) begin
      bad++;
      $display("FAIL reset_outputs: cv,co,nrzi,ur,busy,rdy=%b required 000001",
               {code_valid, code_out, nrzi_out, underrun, busy, din_ready});
    end
  endtask

  task automatic test_word_b3();
    logic [63:0] e;
    do_reset();
    send_word(8'hB3); flush_pulse(); drain();
    e = 64'b0100_1000_0000_1000;
    total++; if (got.size() != 16) begin bad++; $display("FAIL b3_len: got %0d bits required 16", got.size()); end
    total++; if (pack_got() !== e) begin bad++; $display("FAIL b3_code: got %h required %h", pack_got(), e); end
    total++; if (last_v - first_v + 1 != 16) begin bad++; $display("FAIL b3_contig: span %0d required 16", last_v - first_v + 1); end
    total++; if (first_v != acc_cyc + 1) begin bad++; $display("FAIL b3_latency: first bit at %0d required %0d", first_v, acc_cyc + 1); end
  endtask

  task automatic test_word_49();
    logic [63:0] e;
    do_reset();
    send_word(8'h49); flush_pulse(); drain();
    e = 64'b100100_100100_100100;
    total++; if (got.size() != 18) begin bad++; $display("FAIL 49_len: got %0d bits required 18", got.size()); end
    total++; if (pack_got() !== e) begin bad++; $display("FAIL 49_code: got %h required %h", pack_got(), e); end
    total++; if (last_v - first_v + 1 != 18) begin bad++; $display("FAIL 49_contig: span %0d required 18", last_v - first_v + 1); end
    tick();
    total++; if ({busy, underrun, din_ready} !== 3'b001) begin bad++; $display("FAIL 49_idle: busy,ur,rdy=%b required 001", {busy, underrun, din_ready}); end
  endtask

  task automatic test_word_25();
    logic [63:0] e;
    do_reset();
    send_word(8'h25); flush_pulse(); drain();
    e = 64'b00100100_100100_0100;
    total++; if (got.size() != 18) begin bad++; $display("FAIL 25_len: got %0d bits required 18", got.size()); end
    total++; if (pack_got() !== e) begin bad++; $display("FAIL 25_code: got %h required %h", pack_got(), e); end
  endtask

  task automatic test_back_to_back();
    int a [4];
    logic [63:0] e;
    do_reset();
    for (int k = 0; k < 4; k++) begin send_word(8'hFF); a[k] = acc_cyc; end
    drain();
    e = {16{4'b1000}};
    total++; if (a[1] - a[0] != 1)  begin bad++; $display("FAIL b2b_acc1: spacing %0d required 1", a[1] - a[0]); end
    total++; if (a[2] - a[1] != 13) begin bad++; $display("FAIL b2b_acc2: spacing %0d required 13", a[2] - a[1]); end
    total++; if (a[3] - a[2] != 16) begin bad++; $display("FAIL b2b_acc3: spacing %0d required 16", a[3] - a[2]); end
    total++; if (got.size() != 64) begin bad++; $display("FAIL b2b_len: got %0d bits required 64", got.size()); end
    total++; if (pack_got() !== e) begin bad++; $display("FAIL b2b_code: got %h required %h", pack_got(), e); end
    total++; if (last_v - first_v + 1 != 64) begin bad++; $display("FAIL b2b_contig: span %0d required 64", last_v - first_v + 1); end
    total++; if (first_v != a[0] + 1) begin bad++; $display("FAIL b2b_latency: first bit at %0d required %0d", first_v, a[0] + 1); end
  endtask

  task automatic test_underrun();
    logic [63:0] e;
    do_reset();
    send_word(8'h01);
    total++; if ({code_valid, underrun} !== 2'b01) begin bad++; $display("FAIL ur_first: cv,ur=%b required 01", {code_valid, underrun}); end
    repeat (20) tick();
    total++; if ({code_valid, underrun, busy} !== 3'b011) begin bad++; $display("FAIL ur_stall: cv,ur,busy=%b required 011", {code_valid, underrun, busy}); end
    total++; if (got.size() != 12) begin bad++; $display("FAIL ur_len: got %0d bits required 12", got.size()); end
    flush_pulse();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_flush: underrun=%b required 0", underrun); end
    drain();
    e = 64'b000100_000100_100100;
    total++; if (pack_got() !== e || got.size() != 18) begin bad++; $display("FAIL ur_code: got %h (%0d bits) required %h (18)", pack_got(), got.size(), e); end
  endtask

  task automatic test_nrzi();
    logic [63:0] e;
    do_reset();
    send_word(8'hB3); flush_pulse(); drain();
    e = 64'b0011_1000_0000_0111;
    total++; if (pack_nz() !== e) begin bad++; $display("FAIL nrzi_wave: got %h required %h", pack_nz(), e); end
    total++; if (nrzi_out !== 1'b1) begin bad++; $display("FAIL nrzi_end: nrzi_out=%b required 1", nrzi_out); end
  endtask

  task automatic test_flush_idle();
    do_reset();
    flush_pulse();
    total++; if ({busy, din_ready, code_valid} !== 3'b100) begin bad++; $display("FAIL fidle_pend: busy,rdy,cv=%b required 100", {busy, din_ready, code_valid}); end
    tick();
    total++; if ({busy, din_ready, code_valid} !== 3'b010) begin bad++; $display("FAIL fidle_clear: busy,rdy,cv=%b required 010", {busy, din_ready, code_valid}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(8'hFF); send_word(8'hFF);
    repeat (3) tick();
    total++; if ({code_valid, nrzi_out} !== 2'b11) begin bad++; $display("FAIL rmid_pre: cv,nrzi=%b required 11", {code_valid, nrzi_out}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({code_valid, busy, nrzi_out, din_ready, underrun} !== 5'b00010) begin
      bad++;
      $display("FAIL rmid_post: cv,busy,nrzi,rdy,ur=%b required 00010",
               {code_valid, busy, nrzi_out, din_ready, underrun});
    end
  endtask

  task automatic test_random_stream();
    int mis, last1, run;
    do_reset();
    for (int k = 0; k < 6; k++) send_word(8'($urandom_range(0, 255)));
    flush_pulse(); drain();
    build_model();
    total++; if (got.size() != mdl.size()) begin bad++; $display("FAIL rnd_len: got %0d bits required %0d", got.size(), mdl.size()); end
    mis = 0;
    for (int i = 0; i < got.size() && i < mdl.size(); i++) if (got[i] !== mdl[i]) mis++;
    total++; if (mis != 0) begin bad++; $display("FAIL rnd_code: %0d mismatching bits, required 0", mis); end
    last1 = -1;
    foreach (got[i]) begin
      if (got[i]) begin
        if (last1 >= 0) begin
          run = i - last1 - 1;
          total++;
          if (run < 2 || run > 7) begin bad++; $display("FAIL rnd_zero_run: run %0d at bit %0d, required 2..7", run, i); end
        end
        last1 = i;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word_b3();
    test_word_49();
    test_word_25();
    test_back_to_back();
    test_underrun();
    test_nrzi();
    test_flush_idle();
    test_reset_mid();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
